// File: rtl/csa_addsub_pipe.sv
// Two-stage carry-select add/subtract with valid/ready on both sides.
// S1 precomputes per-group sums for carry-in 0 and 1; S2 selects them with the real carry.
module csa_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / BLOCK;

    logic             s2_load;
    logic             s1_load;
    logic             s1_valid;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [NG-1:0][BLOCK-1:0] pre_sum0;
    logic [NG-1:0][BLOCK-1:0] pre_sum1;
    logic [NG-1:0]            pre_c0;
    logic [NG-1:0]            pre_c1;
    logic                     pre_m0;
    logic                     pre_m1;

    logic [NG-1:0][BLOCK-1:0] s1_sum0;
    logic [NG-1:0][BLOCK-1:0] s1_sum1;
    logic [NG-1:0]            s1_c0;
    logic [NG-1:0]            s1_c1;
    logic                     s1_m0;
    logic                     s1_m1;
    logic                     s1_cin;

    logic [WIDTH-1:0] sel_sum;
    logic [NG:0]      carry;
    logic             msb_cin;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load && !rst;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        assign {pre_c0[g], pre_sum0[g]} = {1'b0, a[g*BLOCK +: BLOCK]} + {1'b0, b_eff[g*BLOCK +: BLOCK]};
        assign {pre_c1[g], pre_sum1[g]} = {1'b0, a[g*BLOCK +: BLOCK]} + {1'b0, b_eff[g*BLOCK +: BLOCK]}
                                        + {{BLOCK{1'b0}}, 1'b1};
    end

    // Carry into the MSB recovered from the top sum bit: s = a ^ b ^ c.
    assign pre_m0 = pre_sum0[NG-1][BLOCK-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
    assign pre_m1 = pre_sum1[NG-1][BLOCK-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];

    always_comb begin
        carry    = '0;
        sel_sum  = '0;
        carry[0] = s1_cin;
        for (int g = 0; g < NG; g++) begin
            sel_sum[g*BLOCK +: BLOCK] = carry[g] ? s1_sum1[g] : s1_sum0[g];
            carry[g+1]                = carry[g] ? s1_c1[g] : s1_c0[g];
        end
        msb_cin = carry[NG-1] ? s1_m1 : s1_m0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_cin    <= 1'b0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
            s1_c0     <= '0;
            s1_c1     <= '0;
            s1_m0     <= 1'b0;
            s1_m1     <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_cin  <= cin_eff;
                    s1_sum0 <= pre_sum0;
                    s1_sum1 <= pre_sum1;
                    s1_c0   <= pre_c0;
                    s1_c1   <= pre_c1;
                    s1_m0   <= pre_m0;
                    s1_m1   <= pre_m1;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum  <= sel_sum;
                    cout <= carry[NG];
                    ovf  <= msb_cin ^ carry[NG];
                    zero <= (sel_sum == '0);
                end
            end
        end
    end
endmodule
